// File: rtl/wts_timer_array_if.sv
// Configuration, event and status bundle between the wave table core and its timer array.
// The slave side is the timer array; the master side is the register file and mixer.
interface wts_timer_array_if #(
    parameter int NUM_TIMERS = 2,
    parameter int NUM_CH     = 10,
    parameter int CH_SEL_W   = 4,
    parameter int ADDR_W     = 2,
    parameter int COUNT_W    = 8
) ();
    logic [NUM_CH-1:0]              ch_trigger;
    logic [NUM_CH*ADDR_W-1:0]       ch_address;
    logic [NUM_TIMERS-1:0]          reg_enable;
    logic [NUM_TIMERS-1:0]          reg_oneshot;
    logic [NUM_TIMERS*CH_SEL_W-1:0] reg_channel;
    logic [NUM_TIMERS*ADDR_W-1:0]   reg_match_address;
    logic [NUM_TIMERS*COUNT_W-1:0]  reg_reload;
    logic [NUM_TIMERS-1:0]          reg_irq_mask;
    logic [NUM_TIMERS-1:0]          reg_clear;
    logic [NUM_TIMERS-1:0]          timer_status;
    logic [NUM_TIMERS-1:0]          timer_overrun;
    logic [NUM_TIMERS-1:0]          timer_running;
    logic [NUM_TIMERS*COUNT_W-1:0]  timer_count;
    logic                           nint;

    modport master (
        output ch_trigger, ch_address, reg_enable, reg_oneshot, reg_channel,
               reg_match_address, reg_reload, reg_irq_mask, reg_clear,
        input  timer_status, timer_overrun, timer_running, timer_count, nint
    );

    modport slave (
        input  ch_trigger, ch_address, reg_enable, reg_oneshot, reg_channel,
               reg_match_address, reg_reload, reg_irq_mask, reg_clear,
        output timer_status, timer_overrun, timer_running, timer_count, nint
    );
endinterface

// File: rtl/wts_timer_array.sv
// NUM_TIMERS independent event timers counting wave-position triggers of a selected channel.
// Each timer flags every (reload+1) matching events, with overrun detection and a masked interrupt.
//
// state   | meaning
// IDLE    | stopped, waiting for a rising edge of reg_enable
// RUN     | counting matching events down towards expiry
// DONE    | one-shot expired, held until reg_enable goes low
module wts_timer_array #(
    parameter int NUM_TIMERS = 2,
    parameter int NUM_CH     = 10,
    parameter int CH_SEL_W   = 4,
    parameter int ADDR_W     = 2,
    parameter int COUNT_W    = 8
) (
    input  logic              clk,
    input  logic              nreset,
    wts_timer_array_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state [NUM_TIMERS];
    logic [COUNT_W-1:0]    r_count [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] r_enable_d;
    logic [NUM_TIMERS-1:0] r_status;
    logic [NUM_TIMERS-1:0] r_overrun;
    logic                  r_nint;

    logic [NUM_TIMERS-1:0] w_match;
    logic [NUM_TIMERS-1:0] w_expire;
    logic [NUM_TIMERS-1:0] w_status_next;
    logic [NUM_TIMERS-1:0] w_overrun_next;

    // Selects at or above NUM_CH compare against no channel and so never match.
    always_comb begin
        w_match = '0;
        for (int t = 0; t < NUM_TIMERS; t++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (bus.reg_channel[t*CH_SEL_W +: CH_SEL_W] == CH_SEL_W'(c) &&
                    bus.ch_trigger[c] &&
                    bus.ch_address[c*ADDR_W +: ADDR_W] == bus.reg_match_address[t*ADDR_W +: ADDR_W])
                    w_match[t] = 1'b1;
            end
        end
    end

    // Expiry sets status even under a coincident clear; clear always wins for overrun.
    always_comb begin
        w_expire       = '0;
        w_status_next  = '0;
        w_overrun_next = '0;
        for (int t = 0; t < NUM_TIMERS; t++) begin
            w_expire[t]       = (r_state[t] == ST_RUN) && bus.reg_enable[t] &&
                                w_match[t] && (r_count[t] == '0);
            w_status_next[t]  = w_expire[t] | (r_status[t] & ~bus.reg_clear[t]);
            w_overrun_next[t] = ~bus.reg_clear[t] & (r_overrun[t] | (w_expire[t] & r_status[t]));
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            for (int t = 0; t < NUM_TIMERS; t++) begin
                r_state[t] <= ST_IDLE;
                r_count[t] <= '0;
            end
            r_enable_d <= '0;
            r_status   <= '0;
            r_overrun  <= '0;
            r_nint     <= 1'b1;
        end else begin
            r_enable_d <= bus.reg_enable;
            r_status   <= w_status_next;
            r_overrun  <= w_overrun_next;
            r_nint     <= ~|(w_status_next & bus.reg_irq_mask);
            for (int t = 0; t < NUM_TIMERS; t++) begin
                if (!bus.reg_enable[t]) begin
                    r_state[t] <= ST_IDLE;
                end else begin
                    case (r_state[t])
                        ST_IDLE: begin
                            if (!r_enable_d[t]) begin
                                r_count[t] <= bus.reg_reload[t*COUNT_W +: COUNT_W];
                                r_state[t] <= ST_RUN;
                            end
                        end
                        ST_RUN: begin
                            if (w_expire[t]) begin
                                if (bus.reg_oneshot[t])
                                    r_state[t] <= ST_DONE;
                                else
                                    r_count[t] <= bus.reg_reload[t*COUNT_W +: COUNT_W];
                            end else if (w_match[t]) begin
                                r_count[t] <= r_count[t] - 1'b1;
                            end
                        end
                        ST_DONE: r_state[t] <= ST_DONE;
                        default: r_state[t] <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    for (genvar t = 0; t < NUM_TIMERS; t++) begin : g_out
        assign bus.timer_running[t]                  = (r_state[t] == ST_RUN);
        assign bus.timer_count[t*COUNT_W +: COUNT_W] = r_count[t];
    end

    assign bus.timer_status  = r_status;
    assign bus.timer_overrun = r_overrun;
    assign bus.nint          = r_nint;
endmodule
